writeback_stage: RTL and testbench

//  Parametrised MEM/WB pipeline register plus write-back stage for the MIPS pipeline.

---
 rtl/mips_wb_pkg.sv | 19 +
 rtl/load_extend.sv | 47 ++++
 rtl/writeback_stage.sv | 140 ++++++++++++++
 tb/tb_writeback_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared encodings for the MIPS MEM/WB write-back slice.
//   wb_sel_t  - write-back source select (ALU, LOAD, LINK; code 3 aliases ALU)
//   ld_type_t - load width/extension type (codes 5-7 behave as LW)
package mips_wb_pkg;

  typedef logic [1:0] wb_sel_t;
  typedef logic [2:0] ld_type_t;

  localparam wb_sel_t WB_SEL_ALU  = 2'd0;
  localparam wb_sel_t WB_SEL_LOAD = 2'd1;
  localparam wb_sel_t WB_SEL_LINK = 2'd2;

  localparam ld_type_t LD_LW  = 3'd0;
  localparam ld_type_t LD_LB  = 3'd1;
  localparam ld_type_t LD_LBU = 3'd2;
  localparam ld_type_t LD_LH  = 3'd3;
  localparam ld_type_t LD_LHU = 3'd4;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational sub-word selection and sign/zero extension of a loaded word.
// Ports:
//   data     in   DATA_W  raw memory word
//   loadType in   3       LW/LB/LBU/LH/LHU (5-7 treated as LW)
//   byteOff  in   2       address[1:0]; big-endian byte numbering
//   extended out  DATA_W  value to write back
module load_extend
  import mips_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  ld_type_t          loadType,
  input  logic [1:0]        byteOff,
  output logic [DATA_W-1:0] extended
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Big-endian: offset 0 is the most significant byte of the word.
  always_comb begin
    byteSel = '0;
    unique case (byteOff)
      2'd0: byteSel = data[DATA_W-1  -: 8];
      2'd1: byteSel = data[DATA_W-9  -: 8];
      2'd2: byteSel = data[DATA_W-17 -: 8];
      2'd3: byteSel = data[DATA_W-25 -: 8];
      default: byteSel = '0;
    endcase
  end

  // Only byteOff[1] chooses the half; byteOff[0] is don't-care.
  assign halfSel = byteOff[1] ? data[DATA_W-17 -: 16] : data[DATA_W-1 -: 16];

  always_comb begin
    extended = data;
    case (loadType)
      LD_LB:   extended = {{(DATA_W-8){byteSel[7]}}, byteSel};
      LD_LBU:  extended = {{(DATA_W-8){1'b0}}, byteSel};
      LD_LH:   extended = {{(DATA_W-16){halfSel[15]}}, halfSel};
      LD_LHU:  extended = {{(DATA_W-16){1'b0}}, halfSel};
      default: extended = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, write-back source mux and retire counter.
// Optional feature macro: WB_BYPASS_EN adds a one-entry history of the last register write
// (Hist_* ports) for ID-stage read-after-write forwarding.
// Ports:
//   Clk, Reset           clock; synchronous active-high reset
//   Stall, Flush         hold / bubble the MEM/WB register (Flush wins)
//   MEM_*                MEM-stage results captured on each loading edge
//   WB_RegWrite/WriteReg/WriteData  register-file write port
//   RetireCount          retired instruction count (wraps silently)
//   Hist_Valid/Reg/Data  previous write-port values [WB_BYPASS_EN only]
module writeback_stage
  import mips_wb_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,  // multiple of 16
  parameter int unsigned REGADDR_W = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic                 MEM_Valid,
  input  logic                 MEM_RegWrite,
  input  logic [REGADDR_W-1:0] MEM_WriteReg,
  input  wb_sel_t              MEM_WBSel,
  input  ld_type_t             MEM_LoadType,
  input  logic [1:0]           MEM_ByteOff,
  input  logic [DATA_W-1:0]    MEM_ALUResult,
  input  logic [DATA_W-1:0]    MEM_LoadData,
  input  logic [DATA_W-1:0]    MEM_LinkPC,
  output logic                 WB_RegWrite,
  output logic [REGADDR_W-1:0] WB_WriteReg,
  output logic [DATA_W-1:0]    WB_WriteData,
  output logic [CNT_W-1:0]     RetireCount
`ifdef WB_BYPASS_EN
  ,
  output logic                 Hist_Valid,
  output logic [REGADDR_W-1:0] Hist_Reg,
  output logic [DATA_W-1:0]    Hist_Data
`endif
);

  logic                 validQ;
  logic                 regWriteQ;
  logic [REGADDR_W-1:0] writeRegQ;
  wb_sel_t              wbSelQ;
  ld_type_t             loadTypeQ;
  logic [1:0]           byteOffQ;
  logic [DATA_W-1:0]    aluResultQ;
  logic [DATA_W-1:0]    loadDataQ;
  logic [DATA_W-1:0]    linkPcQ;
  logic [CNT_W-1:0]     retireCountQ;
  logic [DATA_W-1:0]    loadExt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      validQ       <= 1'b0;
      regWriteQ    <= 1'b0;
      writeRegQ    <= '0;
      wbSelQ       <= WB_SEL_ALU;
      loadTypeQ    <= LD_LW;
      byteOffQ     <= '0;
      aluResultQ   <= '0;
      loadDataQ    <= '0;
      linkPcQ      <= '0;
      retireCountQ <= '0;
    end else if (Flush) begin
      // Bubble: every field zeroed so write data reads as 0, not stale values.
      validQ     <= 1'b0;
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      wbSelQ     <= WB_SEL_ALU;
      loadTypeQ  <= LD_LW;
      byteOffQ   <= '0;
      aluResultQ <= '0;
      loadDataQ  <= '0;
      linkPcQ    <= '0;
    end else if (!Stall) begin
      validQ     <= MEM_Valid;
      regWriteQ  <= MEM_RegWrite;
      writeRegQ  <= MEM_WriteReg;
      wbSelQ     <= MEM_WBSel;
      loadTypeQ  <= MEM_LoadType;
      byteOffQ   <= MEM_ByteOff;
      aluResultQ <= MEM_ALUResult;
      loadDataQ  <= MEM_LoadData;
      linkPcQ    <= MEM_LinkPC;
      if (MEM_Valid) begin
        retireCountQ <= retireCountQ + CNT_W'(1);
      end
    end
  end

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .data     (loadDataQ),
    .loadType (loadTypeQ),
    .byteOff  (byteOffQ),
    .extended (loadExt)
  );

  always_comb begin
    WB_WriteData = aluResultQ;
    case (wbSelQ)
      WB_SEL_LOAD: WB_WriteData = loadExt;
      WB_SEL_LINK: WB_WriteData = linkPcQ;
      default:     WB_WriteData = aluResultQ;
    endcase
  end

  // Writes to $0 never reach the register file.
  assign WB_RegWrite = validQ & regWriteQ & (writeRegQ != '0);
  assign WB_WriteReg = writeRegQ;
  assign RetireCount = retireCountQ;

`ifdef WB_BYPASS_EN
  logic                 histValidQ;
  logic [REGADDR_W-1:0] histRegQ;
  logic [DATA_W-1:0]    histDataQ;

  // Flush overrides Stall, so a flushing edge still retires the current write into history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      histValidQ <= 1'b0;
      histRegQ   <= '0;
      histDataQ  <= '0;
    end else if (Flush || !Stall) begin
      histValidQ <= WB_RegWrite;
      histRegQ   <= WB_WriteReg;
      histDataQ  <= WB_WriteData;
    end
  end

  assign Hist_Valid = histValidQ;
  assign Hist_Reg   = histRegQ;
  assign Hist_Data  = histDataQ;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import mips_wb_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, Stall, Flush, MEM_Valid, MEM_RegWrite;
  logic [4:0]  MEM_WriteReg;
  logic [1:0]  MEM_WBSel;
  logic [2:0]  MEM_LoadType;
  logic [1:0]  MEM_ByteOff;
  logic [31:0] MEM_ALUResult, MEM_LoadData, MEM_LinkPC;

  logic        wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbWriteData;
  logic [31:0] retireCount;

  logic        sRegWrite;
  logic [4:0]  sWriteReg;
  logic [31:0] sWriteData;
  logic [3:0]  sRetireCount;

`ifdef WB_BYPASS_EN
  logic        histValid, sHistValid;
  logic [4:0]  histReg, sHistReg;
  logic [31:0] histData, sHistData;
`endif

  writeback_stage dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Flush         (Flush),
    .MEM_Valid     (MEM_Valid),
    .MEM_RegWrite  (MEM_RegWrite),
    .MEM_WriteReg  (MEM_WriteReg),
    .MEM_WBSel     (MEM_WBSel),
    .MEM_LoadType  (MEM_LoadType),
    .MEM_ByteOff   (MEM_ByteOff),
    .MEM_ALUResult (MEM_ALUResult),
    .MEM_LoadData  (MEM_LoadData),
    .MEM_LinkPC    (MEM_LinkPC),
    .WB_RegWrite   (wbRegWrite),
    .WB_WriteReg   (wbWriteReg),
    .WB_WriteData  (wbWriteData),
    .RetireCount   (retireCount)
`ifdef WB_BYPASS_EN
    ,
    .Hist_Valid    (histValid),
    .Hist_Reg      (histReg),
    .Hist_Data     (histData)
`endif
  );

  // Narrow-counter instance fed the same stimulus to exercise wrap-around.
  writeback_stage #(
    .CNT_W (4)
  ) dutSmall (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Flush         (Flush),
    .MEM_Valid     (MEM_Valid),
    .MEM_RegWrite  (MEM_RegWrite),
    .MEM_WriteReg  (MEM_WriteReg),
    .MEM_WBSel     (MEM_WBSel),
    .MEM_LoadType  (MEM_LoadType),
    .MEM_ByteOff   (MEM_ByteOff),
    .MEM_ALUResult (MEM_ALUResult),
    .MEM_LoadData  (MEM_LoadData),
    .MEM_LinkPC    (MEM_LinkPC),
    .WB_RegWrite   (sRegWrite),
    .WB_WriteReg   (sWriteReg),
    .WB_WriteData  (sWriteData),
    .RetireCount   (sRetireCount)
`ifdef WB_BYPASS_EN
    ,
    .Hist_Valid    (sHistValid),
    .Hist_Reg      (sHistReg),
    .Hist_Data     (sHistData)
`endif
  );

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t histExp;
  int   nAsserts = 0;
  int   nFail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic checkOut();
    exp_t e;
    nAsserts++;
    assert (sb.size() > 0)
    else begin
      nFail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("WB_RegWrite", {31'b0, wbRegWrite}, {31'b0, e.rw});
      chk("WB_WriteReg", {27'b0, wbWriteReg}, {27'b0, e.rd});
      chk("WB_WriteData", wbWriteData, e.data);
      chk("RetireCount", retireCount, e.cnt);
      chk("RetireCount4", {28'b0, sRetireCount}, {28'b0, e.cnt[3:0]});
`ifdef WB_BYPASS_EN
      chk("Hist_Valid", {31'b0, histValid}, {31'b0, histExp.rw});
      chk("Hist_Reg", {27'b0, histReg}, {27'b0, histExp.rd});
      chk("Hist_Data", histData, histExp.data);
`endif
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    checkOut();
  endtask

  task automatic garbage();
    MEM_Valid     = 1'b1;
    MEM_RegWrite  = 1'b1;
    MEM_WriteReg  = 5'($urandom_range(1, 31));
    MEM_WBSel     = 2'($urandom);
    MEM_LoadType  = 3'($urandom);
    MEM_ByteOff   = 2'($urandom);
    MEM_ALUResult = $urandom;
    MEM_LoadData  = $urandom;
    MEM_LinkPC    = $urandom;
  endtask

  task automatic issue(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] link,
                       input logic [31:0] expData);
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    MEM_Valid = v; MEM_RegWrite = rw; MEM_WriteReg = rd; MEM_WBSel = sel;
    MEM_LoadType = lt; MEM_ByteOff = off;
    MEM_ALUResult = alu; MEM_LoadData = ld; MEM_LinkPC = link;
    histExp = cur;
    cur.rw   = v & rw & (rd != 5'd0);
    cur.rd   = rd;
    cur.data = expData;
    if (v) cur.cnt = cur.cnt + 1;
    sb.push_back(cur);
    tick();
  endtask

  task automatic stallCycle();
    Reset = 1'b0; Stall = 1'b1; Flush = 1'b0;
    garbage();
    sb.push_back(cur);
    tick();
  endtask

  task automatic flushCycle(input logic withStall);
    Reset = 1'b0; Stall = withStall; Flush = 1'b1;
    garbage();
    histExp = cur;
    cur = '{rw: 1'b0, rd: 5'd0, data: 32'd0, cnt: cur.cnt};
    sb.push_back(cur);
    tick();
  endtask

  task automatic resetCycle(input logic withStall);
    Reset = 1'b1; Stall = withStall; Flush = 1'b0;
    garbage();
    cur = '0;
    histExp = '0;
    sb.push_back(cur);
    tick();
  endtask

  localparam logic [31:0] LdWord = 32'h80FF_7F01;

  initial begin
    cur = '0;
    histExp = '0;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    garbage();
    #1;

    // Reset held two cycles, then idle cycles with MEM_Valid low.
    resetCycle(1'b0);
    resetCycle(1'b0);
    issue(0, 0, 0, WB_SEL_ALU, LD_LW, 0, 0, 0, 0, 32'h0);
    issue(0, 0, 0, WB_SEL_ALU, LD_LW, 0, 0, 0, 0, 32'h0);

    // ALU write.
    issue(1, 1, 8, WB_SEL_ALU, LD_LW, 0, 32'h1234_5678, 0, 0, 32'h1234_5678);

    // Sub-word loads from a big-endian word.
    issue(1, 1, 9, WB_SEL_LOAD, LD_LB,  0, 32'hDEAD_BEEF, LdWord, 0, 32'hFFFF_FF80);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LBU, 1, 32'hDEAD_BEEF, LdWord, 0, 32'h0000_00FF);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LH,  2, 32'hDEAD_BEEF, LdWord, 0, 32'h0000_7F01);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LHU, 0, 32'hDEAD_BEEF, LdWord, 0, 32'h0000_80FF);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LB,  3, 32'hDEAD_BEEF, LdWord, 0, 32'h0000_0001);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LBU, 2, 32'hDEAD_BEEF, LdWord, 0, 32'h0000_007F);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LH,  1, 32'hDEAD_BEEF, LdWord, 0, 32'hFFFF_80FF);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LHU, 3, 32'hDEAD_BEEF, LdWord, 0, 32'h0000_7F01);
    issue(1, 1, 9, WB_SEL_LOAD, LD_LW,  3, 32'hDEAD_BEEF, LdWord, 0, LdWord);
    issue(1, 1, 9, WB_SEL_LOAD, 3'd7,   1, 32'hDEAD_BEEF, LdWord, 0, LdWord);
    issue(1, 1, 9, 2'd3,        LD_LB,  0, 32'hCAFE_F00D, LdWord, 0, 32'hCAFE_F00D);

    // Link write, then the same to $0 (suppressed but still counted).
    issue(1, 1, 31, WB_SEL_LINK, LD_LW, 0, 32'h1111_1111, 0, 32'h0040_0008, 32'h0040_0008);
    issue(1, 1, 0,  WB_SEL_LINK, LD_LW, 0, 32'h1111_1111, 0, 32'h0040_0008, 32'h0040_0008);
    issue(1, 0, 12, WB_SEL_ALU,  LD_LW, 0, 32'h0000_0ABC, 0, 0, 32'h0000_0ABC);

    // Stall freezes everything; Stall+Flush gives a bubble.
    issue(1, 1, 5, WB_SEL_ALU, LD_LW, 0, 32'h5555_AAAA, 0, 0, 32'h5555_AAAA);
    stallCycle();
    stallCycle();
    stallCycle();
    flushCycle(1'b1);
    issue(1, 1, 6, WB_SEL_ALU, LD_LW, 0, 32'h0606_0606, 0, 0, 32'h0606_0606);
    flushCycle(1'b0);

    // Reset while stalled discards the held instruction.
    issue(1, 1, 7, WB_SEL_ALU, LD_LW, 0, 32'h0707_0707, 0, 0, 32'h0707_0707);
    stallCycle();
    resetCycle(1'b1);

    // 17 valid instructions: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      issue(1, 1, 5'(i), WB_SEL_ALU, LD_LW, 0, 32'(i) * 32'h0101_0101, 0, 0,
            32'(i) * 32'h0101_0101);
    end
    chk("Wrap4", {28'b0, sRetireCount}, 32'd1);
    chk("Count17", retireCount, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
